// File: rtl/mat_cache_seq.sv
// Command sequencer for the matrix cache: paces READ/WRITE diagonal streams and TRANSPOSE.
// Optional stall counter output enabled by defining MAT_CACHE_SEQ_PERF_EN.
module mat_cache_seq #(
   parameter int WIDTH           = 128,
   parameter int DIAG_SIZE       = 1 + $clog2(WIDTH),
   parameter int CACHE_SIZE      = 4,
   parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr1,
   input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr2,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       read_enable,
   output logic                       write_enable,
   output logic                       transpose_enable,
   output logic [CACHE_ADDR_SIZE-1:0] read_addr1,
   output logic [CACHE_ADDR_SIZE-1:0] read_addr2,
   output logic [CACHE_ADDR_SIZE-1:0] write_addr1,
   output logic [CACHE_ADDR_SIZE-1:0] write_addr2,
   output logic [DIAG_SIZE-1:0]       read_diag,
   output logic [DIAG_SIZE-1:0]       write_diag,
   output logic                       busy,
   output logic                       done,
   output logic                       cmd_err
`ifdef MAT_CACHE_SEQ_PERF_EN
   ,
   output logic [31:0]                stall_count
`endif
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, XPOSE, NOP} state_t;

   localparam logic [DIAG_SIZE-1:0] LAST_DIAG = DIAG_SIZE'(WIDTH - 1);

   state_t                     state;
   logic [DIAG_SIZE-1:0]       diag;
   logic [CACHE_ADDR_SIZE-1:0] addr1_q;
   logic [CACHE_ADDR_SIZE-1:0] addr2_q;

   // The diag counter returns to 0 on the final beat so it never reaches WIDTH.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         diag    <= '0;
         addr1_q <= '0;
         addr2_q <= '0;
         done    <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         done    <= 1'b0;
         cmd_err <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr1_q <= cmd_addr1;
                  addr2_q <= cmd_addr2;
                  diag    <= '0;
                  case (cmd_op)
                     2'd0:    state <= READ;
                     2'd1:    state <= WRITE;
                     2'd2:    state <= XPOSE;
                     default: state <= NOP;
                  endcase
               end
            end
            READ: begin
               if (out_ready) begin
                  if (diag == LAST_DIAG) begin
                     state <= IDLE;
                     diag  <= '0;
                     done  <= 1'b1;
                  end else begin
                     diag <= diag + DIAG_SIZE'(1);
                  end
               end
            end
            WRITE: begin
               if (in_valid) begin
                  if (diag == LAST_DIAG) begin
                     state <= IDLE;
                     diag  <= '0;
                     done  <= 1'b1;
                  end else begin
                     diag <= diag + DIAG_SIZE'(1);
                  end
               end
            end
            XPOSE: begin
               state <= IDLE;
               done  <= 1'b1;
            end
            NOP: begin
               state   <= IDLE;
               done    <= 1'b1;
               cmd_err <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // cmd_ready is gated by reset_n so nothing is offered while reset is held.
   assign cmd_ready = reset_n && (state == IDLE);
   assign busy      = (state != IDLE);

   // Cache controls decode from state; idle outputs are forced to zero.
   always_comb begin
      out_valid        = 1'b0;
      in_ready         = 1'b0;
      read_enable      = 1'b0;
      write_enable     = 1'b0;
      transpose_enable = 1'b0;
      read_addr1       = '0;
      read_addr2       = '0;
      write_addr1      = '0;
      write_addr2      = '0;
      read_diag        = '0;
      write_diag       = '0;
      case (state)
         READ: begin
            out_valid   = 1'b1;
            read_enable = 1'b1;
            read_addr1  = addr1_q;
            read_addr2  = addr2_q;
            read_diag   = diag;
         end
         WRITE: begin
            in_ready     = 1'b1;
            write_enable = in_valid;
            write_addr1  = addr1_q;
            write_addr2  = addr2_q;
            write_diag   = diag;
         end
         XPOSE: begin
            transpose_enable = 1'b1;
            write_addr1      = addr1_q;
         end
         default: ;
      endcase
   end

`ifdef MAT_CACHE_SEQ_PERF_EN
   // Saturating count of cycles where a stream is waiting on its partner.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (((state == READ && !out_ready) || (state == WRITE && !in_valid))
                   && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`else
   // Build without the stall counter.
`endif

endmodule

// File: tb/tb_mat_cache_seq.sv
// Directed self-checking bench for mat_cache_seq at WIDTH=4.
// Stall-count checks are included when MAT_CACHE_SEQ_PERF_EN is defined.
module tb_mat_cache_seq;

   localparam int WIDTH = 4;
   localparam int DIAG_SIZE = 3;
   localparam int CAS = 2;

   logic clock;
   logic reset_n;
   logic cmd_valid;
   logic cmd_ready;
   logic [1:0] cmd_op;
   logic [CAS-1:0] cmd_addr1;
   logic [CAS-1:0] cmd_addr2;
   logic out_valid;
   logic out_ready;
   logic in_valid;
   logic in_ready;
   logic read_enable;
   logic write_enable;
   logic transpose_enable;
   logic [CAS-1:0] read_addr1;
   logic [CAS-1:0] read_addr2;
   logic [CAS-1:0] write_addr1;
   logic [CAS-1:0] write_addr2;
   logic [DIAG_SIZE-1:0] read_diag;
   logic [DIAG_SIZE-1:0] write_diag;
   logic busy;
   logic done;
   logic cmd_err;
`ifdef MAT_CACHE_SEQ_PERF_EN
   logic [31:0] stall_count;
`endif

   int compared = 0;
   int mismatched = 0;

   mat_cache_seq #(.WIDTH(WIDTH)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_addr1(cmd_addr1),
      .cmd_addr2(cmd_addr2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .read_enable(read_enable),
      .write_enable(write_enable),
      .transpose_enable(transpose_enable),
      .read_addr1(read_addr1),
      .read_addr2(read_addr2),
      .write_addr1(write_addr1),
      .write_addr2(write_addr2),
      .read_diag(read_diag),
      .write_diag(write_diag),
      .busy(busy),
      .done(done),
      .cmd_err(cmd_err)
`ifdef MAT_CACHE_SEQ_PERF_EN
      ,
      .stall_count(stall_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; checks follow 2 units later.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic v, input logic [1:0] op, input logic [CAS-1:0] a1,
                                 input logic [CAS-1:0] a2, input logic ordy, input logic ivld);
      cmd_valid = v;
      cmd_op    = op;
      cmd_addr1 = a1;
      cmd_addr2 = a2;
      out_ready = ordy;
      in_valid  = ivld;
      #2;
   endtask

   logic stall_ready[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   int   stall_diag[7]  = '{0, 1, 2, 2, 2, 2, 3};
   logic wr_valid[6]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   int   wr_diag[6]     = '{0, 1, 1, 2, 3, 3};

   initial begin
      reset_n = 1'b0;
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("rst_cmd_ready", cmd_ready, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_out_valid", out_valid, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      #2;
      check_output("post_rst_cmd_ready", cmd_ready, 1);
      check_output("post_rst_done", done, 0);
      next_cycle();

      $display("[TB] read stream, out_ready held high");
      apply_stimulus(1, 2'd0, 2'd1, 2'd2, 1, 0);
      check_output("rd_accept_ready", cmd_ready, 1);
      next_cycle();
      for (int i = 0; i < WIDTH; i++) begin
         apply_stimulus(0, 0, 0, 0, 1, 0);
         check_output("rd_diag", read_diag, i);
         check_output("rd_enable", read_enable, 1);
         check_output("rd_out_valid", out_valid, 1);
         check_output("rd_addr1", read_addr1, 1);
         check_output("rd_addr2", read_addr2, 2);
         check_output("rd_busy", busy, 1);
         check_output("rd_done_early", done, 0);
         next_cycle();
      end
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("rd_done", done, 1);
      check_output("rd_done_busy", busy, 0);
      check_output("rd_done_ready", cmd_ready, 1);
      check_output("rd_done_enable", read_enable, 0);
      check_output("rd_done_addr1", read_addr1, 0);
      check_output("rd_done_err", cmd_err, 0);
      next_cycle();
      check_output("rd_done_single", done, 0);

      $display("[TB] read stream with a stall on beat 2");
      apply_stimulus(1, 2'd0, 2'd3, 2'd0, 0, 0);
      next_cycle();
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(0, 0, 0, 0, stall_ready[i], 0);
         check_output("st_diag", read_diag, stall_diag[i]);
         check_output("st_out_valid", out_valid, 1);
         check_output("st_addr1", read_addr1, 3);
         check_output("st_done_early", done, 0);
         next_cycle();
      end
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("st_done", done, 1);
`ifdef MAT_CACHE_SEQ_PERF_EN
      check_output("st_stall_count", stall_count, 3);
`endif
      next_cycle();
      check_output("st_done_single", done, 0);

      $display("[TB] write stream with gapped in_valid");
      apply_stimulus(1, 2'd1, 2'd3, 2'd1, 0, 0);
      check_output("wr_accept_ready", cmd_ready, 1);
      next_cycle();
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(0, 0, 0, 0, 0, wr_valid[i]);
         check_output("wr_diag", write_diag, wr_diag[i]);
         check_output("wr_enable", write_enable, wr_valid[i]);
         check_output("wr_in_ready", in_ready, 1);
         check_output("wr_addr1", write_addr1, 3);
         check_output("wr_addr2", write_addr2, 1);
         check_output("wr_rd_enable", read_enable, 0);
         check_output("wr_done_early", done, 0);
         next_cycle();
      end
      apply_stimulus(0, 0, 0, 0, 0, 1);
      check_output("wr_done", done, 1);
      check_output("wr_done_in_ready", in_ready, 0);
      check_output("wr_done_enable", write_enable, 0);
`ifdef MAT_CACHE_SEQ_PERF_EN
      check_output("wr_stall_count", stall_count, 5);
`endif
      next_cycle();

      $display("[TB] transpose and reserved op");
      apply_stimulus(1, 2'd2, 2'd2, 2'd3, 0, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("xp_enable", transpose_enable, 1);
      check_output("xp_addr1", write_addr1, 2);
      check_output("xp_wr_enable", write_enable, 0);
      check_output("xp_busy", busy, 1);
      check_output("xp_done_early", done, 0);
      next_cycle();
      check_output("xp_done", done, 1);
      check_output("xp_enable_off", transpose_enable, 0);
      check_output("xp_err", cmd_err, 0);
      apply_stimulus(1, 2'd3, 2'd1, 2'd1, 1, 1);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 1, 1);
      check_output("nop_busy", busy, 1);
      check_output("nop_ctrl", {read_enable, write_enable, transpose_enable, out_valid, in_ready}, 0);
      check_output("nop_done_early", done, 0);
      next_cycle();
      check_output("nop_done", done, 1);
      check_output("nop_err", cmd_err, 1);
      next_cycle();
      check_output("nop_err_single", cmd_err, 0);
      check_output("nop_done_single", done, 0);

      $display("[TB] asynchronous reset during a read");
      apply_stimulus(1, 2'd0, 2'd1, 2'd2, 1, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 1, 0);
      next_cycle();
      apply_stimulus(0, 0, 0, 0, 1, 0);
      check_output("ar_diag_before", read_diag, 1);
      reset_n = 1'b0;
      #1;
      check_output("ar_out_valid", out_valid, 0);
      check_output("ar_rd_enable", read_enable, 0);
      check_output("ar_addr1", read_addr1, 0);
      check_output("ar_busy", busy, 0);
      check_output("ar_cmd_ready", cmd_ready, 0);
      check_output("ar_done", done, 0);
      next_cycle();
      reset_n = 1'b1;
      #2;
      check_output("ar_rel_ready", cmd_ready, 1);
      check_output("ar_rel_done", done, 0);
`ifdef MAT_CACHE_SEQ_PERF_EN
      check_output("ar_stall_count", stall_count, 0);
`endif
      next_cycle();
      check_output("ar_rel_done2", done, 0);
      check_output("ar_rel_busy", busy, 0);

      $display("[TB] back-to-back commands with cmd_valid held");
      apply_stimulus(1, 2'd0, 2'd0, 2'd1, 1, 1);
      check_output("bb_ready0", cmd_ready, 1);
      next_cycle();
      for (int i = 0; i < WIDTH; i++) begin
         apply_stimulus(1, 2'd1, 2'd2, 2'd3, 1, 1);
         check_output("bb_rd_diag", read_diag, i);
         check_output("bb_rd_ready", cmd_ready, 0);
         next_cycle();
      end
      apply_stimulus(1, 2'd1, 2'd2, 2'd3, 1, 1);
      check_output("bb_rd_done", done, 1);
      check_output("bb_rd_done_ready", cmd_ready, 1);
      next_cycle();
      for (int i = 0; i < WIDTH; i++) begin
         apply_stimulus(1, 2'd0, 2'd1, 2'd1, 1, 1);
         check_output("bb_wr_diag", write_diag, i);
         check_output("bb_wr_addr1", write_addr1, 2);
         check_output("bb_wr_ready", cmd_ready, 0);
         next_cycle();
      end
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("bb_wr_done", done, 1);
      check_output("bb_wr_done_ready", cmd_ready, 1);
      next_cycle();
      check_output("bb_idle_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
